// File: rtl/sched_pkg.sv
// Shared slot numbering, FSM encoding and the priority pick used by the
// control-loop rate scheduler.
package sched_pkg;

    localparam int NSLOT  = 3;
    localparam int SLOT_W = $clog2(NSLOT);
    localparam int SLOT_H = 0;
    localparam int SLOT_M = 1;
    localparam int SLOT_L = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    typedef logic [NSLOT-1:0] slot_vec_t;

    // Lowest set index has the highest priority (H > M > L).
    function automatic logic [SLOT_W-1:0] lowest_set(input slot_vec_t v);
        lowest_set = SLOT_W'(SLOT_L);
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SLOT_W'(i);
        end
    endfunction

endpackage

// File: rtl/control_scheduler_rate_ticker.sv
// Free-running prescaler: one registered single-cycle tick every DIV cycles
// while en is high; en low parks the count at 0.
module rate_ticker #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/control_scheduler.sv
// Rate scheduler: three aligned rate ticks, one pending request per rate,
// non-preemptive fixed-priority grant of a single shared task slot.
//
//   state | meaning
//   IDLE  | no grant; picks highest-priority pending rate if any
//   RUN   | one slot granted; watchdog counts until done or TMO-1
module control_scheduler
    import sched_pkg::*;
#(
    parameter int DIV_H = 100,
    parameter int DIV_M = 1000,
    parameter int DIV_L = 10000,
    parameter int TMO   = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        task_done,
    input  logic        ovr_clr,
    output logic [2:0]  tick,
    output logic [2:0]  task_req,
    output logic        busy,
    output logic [2:0]  ovr,
    output logic [2:0]  tmo,
    output logic [15:0] frame_cnt
);

    localparam int            WW      = $clog2(TMO);
    localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);

    sched_state_t      state, state_nxt;
    slot_vec_t         pend, pend_nxt;
    slot_vec_t         req_nxt;
    slot_vec_t         ovr_set, tmo_set;
    slot_vec_t         ovr_nxt, tmo_nxt;
    logic [SLOT_W-1:0] sel, sel_nxt;
    logic [WW-1:0]     wdog, wdog_nxt;

    rate_ticker #(.DIV(DIV_H)) u_tick_h (.clk(clk), .rst(rst), .en(en), .tick(tick[SLOT_H]));
    rate_ticker #(.DIV(DIV_M)) u_tick_m (.clk(clk), .rst(rst), .en(en), .tick(tick[SLOT_M]));
    rate_ticker #(.DIV(DIV_L)) u_tick_l (.clk(clk), .rst(rst), .en(en), .tick(tick[SLOT_L]));

    assign busy = (state == RUN);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        req_nxt   = task_req;
        sel_nxt   = sel;
        wdog_nxt  = wdog;
        ovr_set   = '0;
        tmo_set   = '0;

        // A tick that finds its rate still pending or still running is dropped.
        for (int i = 0; i < NSLOT; i++) begin
            if (tick[i]) begin
                if (pend[i] || task_req[i]) ovr_set[i] = 1'b1;
                else                        pend_nxt[i] = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (pend != '0) begin
                    sel_nxt           = lowest_set(pend);
                    pend_nxt[sel_nxt] = 1'b0;
                    req_nxt           = slot_vec_t'(1) << sel_nxt;
                    wdog_nxt          = '0;
                    state_nxt         = RUN;
                end
            end
            RUN: begin
                wdog_nxt = wdog + WW'(1);
                if (task_done) begin
                    req_nxt   = '0;
                    state_nxt = IDLE;
                end else if (wdog == WD_LAST) begin
                    tmo_set[sel] = 1'b1;
                    req_nxt      = '0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ovr_nxt = (ovr & ~{NSLOT{ovr_clr}}) | ovr_set;
        tmo_nxt = (tmo & ~{NSLOT{ovr_clr}}) | tmo_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            task_req  <= '0;
            sel       <= '0;
            wdog      <= '0;
            ovr       <= '0;
            tmo       <= '0;
            frame_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            task_req <= req_nxt;
            sel      <= sel_nxt;
            wdog     <= wdog_nxt;
            ovr      <= ovr_nxt;
            tmo      <= tmo_nxt;
            if (tick[SLOT_L]) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_control_scheduler.sv
// Directed bench for control_scheduler: expected grants are queued when the
// schedule is known and checked as the DUT raises task_req.
module tb_control_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, task_done = 1'b0, ovr_clr = 1'b0;
    logic [2:0]  tick, task_req, ovr, tmo;
    logic        busy;
    logic [15:0] frame_cnt;

    logic        en_b = 1'b0, done_b = 1'b0, clr_b = 1'b0;
    logic [2:0]  tick_b, req_b, ovr_b, tmo_b;
    logic        busy_b;
    logic [15:0] frame_b;

    control_scheduler dut (
        .clk(clk), .rst(rst), .en(en), .task_done(task_done), .ovr_clr(ovr_clr),
        .tick(tick), .task_req(task_req), .busy(busy), .ovr(ovr), .tmo(tmo),
        .frame_cnt(frame_cnt)
    );

    control_scheduler #(.DIV_H(100), .DIV_M(1000), .DIV_L(10000), .TMO(200)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .task_done(done_b), .ovr_clr(clr_b),
        .tick(tick_b), .task_req(req_b), .busy(busy_b), .ovr(ovr_b), .tmo(tmo_b),
        .frame_cnt(frame_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int base, c0, c1, n;
    logic flag;

    typedef struct {
        logic [2:0] req;
        int         cyc;
        int         hold;
    } grant_t;
    grant_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [2:0] r, input int c, input int h);
        grant_t e;
        e.req  = r;
        e.cyc  = c;
        e.hold = h;
        sb.push_back(e);
    endtask

    // H every 100 cycles; M every 1000 follows the 5-cycle H task plus one idle cycle.
    task automatic push_window(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            push(3'b001, base + k * 100 + 2, 5);
            if (k % 10 == 0) push(3'b010, base + k * 100 + 8, 5);
        end
    endtask

    task automatic wait_req(input int budget);
        int w = 0;
        while (task_req === 3'b000 && w < budget) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic serve_next();
        grant_t e;
        e = sb.pop_front();
        wait_req(250);
        chk("grant_req", task_req, e.req);
        chk("grant_cyc", cyc, e.cyc);
        repeat (e.hold - 1) @(negedge clk);
        task_done = 1'b1;
        @(negedge clk);
        task_done = 1'b0;
        chk("req_drop", {busy, task_req}, 0);
    endtask

    task automatic drain();
        while (sb.size() > 0) serve_next();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_a", {tick, task_req, busy, ovr, tmo, frame_cnt}, 0);
        chk("rst_b", {tick_b, req_b, busy_b, ovr_b, tmo_b, frame_b}, 0);

        rst  = 1'b0;
        en   = 1'b1;
        base = cyc;

        n = 0;
        while (tick === 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("first_tick", tick, 3'b001);
        chk("first_tick_cyc", cyc, base + 100);

        push_window(1, 99);
        drain();
        chk("ovr_pre_frame", ovr, 0);
        chk("frame_pre", frame_cnt, 0);

        push(3'b001, base + 10002, 10);
        push(3'b010, base + 10013, 10);
        push(3'b100, base + 10024, 10);
        drain();
        chk("frame_cnt1", frame_cnt, 1);

        // H task that never finishes
        wait_req(250);
        chk("tmo_req", task_req, 3'b001);
        chk("tmo_grant_cyc", cyc, base + 10102);
        n = 0;
        while (task_req !== 3'b000 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_len", n, 80);
        chk("tmo_flag", tmo, 3'b001);
        chk("tmo_busy", busy, 0);

        push(3'b001, base + 10202, 5);
        drain();
        chk("tmo_sticky", tmo, 3'b001);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("tmo_clr", tmo, 0);

        // done coincides with watchdog expiry
        push(3'b001, base + 10302, 80);
        drain();
        chk("done_at_expiry", tmo, 0);

        wait_until(base + 10390);
        task_done = 1'b1;
        @(negedge clk);
        task_done = 1'b0;
        chk("idle_done", {busy, task_req, tmo}, 0);

        push(3'b001, base + 10402, 5);
        push_window(105, 199);
        drain();
        chk("ovr_mid", ovr, 0);

        // en dropped during M grant with L pending
        push(3'b001, base + 20002, 5);
        drain();
        wait_req(250);
        chk("m_req", task_req, 3'b010);
        chk("m_cyc", cyc, base + 20008);
        en = 1'b0;
        repeat (4) @(negedge clk);
        task_done = 1'b1;
        @(negedge clk);
        task_done = 1'b0;
        chk("m_drop", task_req, 0);
        push(3'b100, base + 20014, 5);
        drain();
        flag = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (tick !== 3'b000 || task_req !== 3'b000) flag = 1'b1;
        end
        chk("quiet_after_en0", flag, 0);
        chk("frame_cnt2", frame_cnt, 2);
        chk("flags_end", {ovr, tmo}, 0);

        // reset in the middle of a grant
        en = 1'b1;
        c0 = cyc;
        wait_req(250);
        chk("re_req", task_req, 3'b001);
        chk("re_cyc", cyc, c0 + 102);
        repeat (3) @(negedge clk);
        chk("re_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_run", {tick, task_req, busy, ovr, tmo, frame_cnt}, 0);
        rst = 1'b0;
        en  = 1'b0;

        // long H task on the TMO=200 instance
        @(negedge clk);
        en_b = 1'b1;
        c1   = cyc;
        n = 0;
        while (req_b === 3'b000 && n < 250) begin
            @(negedge clk);
            n++;
        end
        chk("b_req", req_b, 3'b001);
        chk("b_cyc", cyc, c1 + 102);
        flag = 1'b0;
        repeat (149) begin
            @(negedge clk);
            if (req_b !== 3'b001) flag = 1'b1;
        end
        done_b = 1'b1;
        @(negedge clk);
        done_b = 1'b0;
        chk("b_hold", flag, 0);
        chk("b_ovr", ovr_b, 3'b001);
        chk("b_tmo", tmo_b, 0);
        chk("b_drop", req_b, 0);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("b_clr", ovr_b, 0);

        n = 0;
        while (req_b === 3'b000 && n < 250) begin
            @(negedge clk);
            n++;
        end
        chk("b_req2", req_b, 3'b001);
        chk("b_cyc2", cyc, c1 + 302);

        // clear and overrun on the same edge: overrun wins
        wait_until(c1 + 400);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("b_set_wins", ovr_b, 3'b001);
        wait_until(c1 + 419);
        done_b = 1'b1;
        @(negedge clk);
        done_b = 1'b0;
        chk("b_drop2", {req_b, tmo_b}, 0);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        chk("b_clr2", ovr_b, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
